// File: rtl/instr_mem_ctrl_pkg.sv
// Shared types and helpers for the instruction-memory slave and its upstream decoder.
// The address check lives here so both sides agree on what counts as a bad fetch.
package instr_mem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ACCESS = 3'd2,
        RESP   = 3'd3,
        ERR    = 3'd4
    } state_e;

    localparam int unsigned ERR_CNT_W  = 16;
    localparam int unsigned WAIT_CNT_W = 4;

    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 32'd1) ? $clog2(words) : 32'd1;
    endfunction

    // The upper bound is formed in 33 bits so a window ending at 4 GiB cannot wrap.
    function automatic logic addr_is_err(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned words);
        logic [32:0] limit_v;
        limit_v = {1'b0, base} + (33'(words) << 2);
        return (addr < base) || ({1'b0, addr} >= limit_v) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Fetch port between the instruction-memory decoder (master) and the memory slave.
interface instr_mem_ctrl_if;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] addr;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/instr_mem_ctrl.sv
// Instruction-memory slave: grants fetches, inserts wait states, reads a 1-cycle SRAM,
// and answers out-of-range or misaligned fetches with an error response.
module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
    parameter int unsigned MEM_WORDS   = 65536,
    parameter int unsigned WAIT_STATES = 0,
    localparam int unsigned IDX_W      = idx_width(MEM_WORDS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    instr_mem_ctrl_if.slave      bus,
    output logic                 mem_req_o,
    output logic [IDX_W-1:0]     mem_addr_o,
    input  logic [31:0]          mem_rdata_i,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    state_e                state_r;
    state_e                state_s;
    logic [WAIT_CNT_W-1:0] wait_cnt_r;
    logic [IDX_W-1:0]      mem_addr_r;
    logic                  rvalid_r;
    logic                  err_r;
    logic                  mem_req_r;
    logic [ERR_CNT_W-1:0]  err_cnt_r;

    logic                  gnt_s;
    logic                  req_err_s;
    logic [IDX_W-1:0]      mem_idx_s;
    logic [31:0]           rdata_s;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; ERR never grants, so it always falls back to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, RESP, ERR: begin
                if (gnt_s && req_err_s) begin
                    state_s = ERR;
                end else if (gnt_s) begin
                    state_s = (WAIT_STATES > 32'd0) ? WAIT : ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_r == {WAIT_CNT_W{1'b0}}) begin
                    state_s = ACCESS;
                end else begin
                    state_s = WAIT;
                end
            end
            ACCESS:  state_s = RESP;
            default: state_s = IDLE;
        endcase
    end

    // Grant, fetch classification and read-data steering.
    always_comb begin
        gnt_s     = bus.req && ((state_r == IDLE) || (state_r == RESP));
        req_err_s = addr_is_err(bus.addr, MEM_BASE, MEM_WORDS);
        mem_idx_s = IDX_W'((bus.addr - MEM_BASE) >> 2);
        if (rvalid_r && !err_r) begin
            rdata_s = mem_rdata_i;
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Wait counter, latched SRAM index and response qualifiers, all keyed on the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_r <= {WAIT_CNT_W{1'b0}};
            mem_addr_r <= {IDX_W{1'b0}};
            rvalid_r   <= 1'b0;
            err_r      <= 1'b0;
            mem_req_r  <= 1'b0;
        end else begin
            if (gnt_s && !req_err_s) begin
                wait_cnt_r <= WAIT_CNT_W'(WAIT_STATES - 32'd1);
                mem_addr_r <= mem_idx_s;
            end else if ((state_r == WAIT) && (wait_cnt_r != {WAIT_CNT_W{1'b0}})) begin
                wait_cnt_r <= wait_cnt_r - WAIT_CNT_W'(1);
            end
            rvalid_r  <= (state_s == RESP) || (state_s == ERR);
            err_r     <= (state_s == ERR);
            mem_req_r <= (state_s == ACCESS);
        end
    end

    // Saturating error-response counter, bumped as each error response retires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if ((state_r == ERR) && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
        end
    end

    assign bus.gnt     = gnt_s;
    assign bus.rvalid  = rvalid_r;
    assign bus.err     = err_r;
    assign bus.rdata   = rdata_s;
    assign mem_req_o   = mem_req_r;
    assign mem_addr_o  = mem_addr_r;
    assign err_count_o = err_cnt_r;

endmodule
